crono_bcd_lap: RTL and testbench

//  Parametrised BCD stopwatch/timer: N_DIGITS cascaded BCD digits, sexagesimal or decimal.
//  - Internal tick prescaler; run/pause toggle; clear; preload.
//  - Count up or down (countdown auto-stops at zero); lap/split freeze of the display.
//  - Feeds the 7-segment display mux; generalises the fixed 00-59 chronometer.

---
 rtl/crono_bcd_lap.sv | 108 ++++++++++
 tb/tb_crono_bcd_lap.sv | 114 +++++++++++
 2 files changed

// File: rtl/crono_bcd_lap.sv
// crono_bcd_lap: BCD stopwatch/timer with prescaler, up/down count, preload and lap freeze
module crono_bcd_lap #(
  parameter int N_DIGITS = 4,
  parameter int SEXAG    = 1,
  parameter int PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  clr,
  input  logic                  lap,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] count,
  output logic [4*N_DIGITS-1:0] disp,
  output logic                  running,
  output logic                  lap_active,
  output logic                  wrap,
  output logic                  done
);
  localparam int W  = 4 * N_DIGITS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic {PAUSE, RUN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] count_q, count_d, lap_q, lap_d, up_v, dn_v, ld_v, base;
  logic [PW-1:0] pre_q, pre_d;
  logic lap_act_q, lap_act_d, wrap_q, wrap_d, done_q, done_d, tick, cy, bw;
  logic [3:0] mx, dg, lv;
  // Ripple carry/borrow across digits; cy ends high at all-max, bw ends high at zero
  always_comb begin
    cy = 1'b1;
    bw = 1'b1;
    mx = 4'd9;
    dg = '0;
    lv = '0;
    up_v = '0;
    dn_v = '0;
    ld_v = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      mx = (SEXAG != 0 && i % 2 == 1) ? 4'd5 : 4'd9;
      dg = count_q[4*i +: 4];
      lv = load_val[4*i +: 4];
      up_v[4*i +: 4] = cy ? (dg == mx ? 4'd0 : dg + 4'd1) : dg;
      dn_v[4*i +: 4] = bw ? (dg == 4'd0 ? mx : dg - 4'd1) : dg;
      ld_v[4*i +: 4] = lv > mx ? mx : lv;
      cy = cy && dg == mx;
      bw = bw && dg == 4'd0;
    end
  end
  always_comb begin
    tick = state_q == RUN && pre_q == PW'(PRESCALE - 1) && !start_stop && !clr;
    base = load ? ld_v : count_q;
    state_d = state_q;
    count_d = count_q;
    pre_d = pre_q;
    lap_act_d = lap_act_q ^ lap;
    lap_d = (lap && !lap_act_q) ? count_q : lap_q;
    wrap_d = 1'b0;
    done_d = 1'b0;
    if (clr) begin
      count_d = '0;
      pre_d = '0;
      state_d = PAUSE;
      lap_act_d = 1'b0;
    end else if (state_q == PAUSE) begin
      count_d = base;
      state_d = (start_stop && !(dir && base == '0)) ? RUN : PAUSE;
    end else if (start_stop) begin
      state_d = PAUSE;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick && !dir) begin
        count_d = up_v;
        wrap_d = cy;
      end else if (tick && !bw) begin
        count_d = dn_v;
        done_d = dn_v == '0;
        state_d = dn_v == '0 ? PAUSE : RUN;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAUSE;
      count_q <= '0;
      lap_q <= '0;
      pre_q <= '0;
      lap_act_q <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lap_q <= lap_d;
      pre_q <= pre_d;
      lap_act_q <= lap_act_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end
  assign count = count_q;
  assign disp = lap_act_q ? lap_q : count_q;
  assign running = state_q == RUN;
  assign lap_active = lap_act_q;
  assign wrap = wrap_q;
  assign done = done_q;
endmodule

// File: tb/tb_crono_bcd_lap.sv
// tb_crono_bcd_lap: vector table against a sexagesimal and a decimal instance, plus reset sequences
module tb_crono_bcd_lap;
  logic clk = 0, rst = 1, ss = 0, cl = 0, lp = 0, dr = 0, ld = 0;
  logic [15:0] lv = '0;
  logic [15:0] count_a, disp_a, count_b, disp_b;
  logic run_a, lapa_a, wrap_a, done_a, run_b, lapa_b, wrap_b, done_b;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  crono_bcd_lap #(.N_DIGITS(4), .SEXAG(1), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .start_stop(ss), .clr(cl), .lap(lp), .dir(dr), .load(ld),
    .load_val(lv), .count(count_a), .disp(disp_a), .running(run_a), .lap_active(lapa_a),
    .wrap(wrap_a), .done(done_a));
  crono_bcd_lap #(.N_DIGITS(4), .SEXAG(0), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .start_stop(ss), .clr(cl), .lap(lp), .dir(dr), .load(ld),
    .load_val(lv), .count(count_b), .disp(disp_b), .running(run_b), .lap_active(lapa_b),
    .wrap(wrap_b), .done(done_b));
  typedef struct {
    logic ss, cl, lp, dr, ld;
    logic [15:0] lv;
    int n;
    logic [15:0] ec, ed, eb;
    logic er, ea, ew, eo;
  } vec_t;
  vec_t v[$];
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    step(2);
    check("rst count", count_a, 16'h0);
    check("rst disp", disp_a, 16'h0);
    check("rst running", 16'(run_a), 16'h0);
    check("rst lap_active", 16'(lapa_a), 16'h0);
    check("rst wrap", 16'(wrap_a), 16'h0);
    check("rst done", 16'(done_a), 16'h0);
    rst = 0;
    //            ss cl lp dr ld lv        n   count    disp     count_b  run lap wrp don
    v.push_back('{1, 0, 0, 0, 0, 16'h0000, 9, 16'h0002, 16'h0002, 16'h0002, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 3, 16'h0002, 16'h0002, 16'h0002, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 1, 16'h0003, 16'h0003, 16'h0003, 1, 0, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 1, 16'h0958, 1, 16'h0958, 16'h0958, 16'h0958, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 4, 16'h0959, 16'h0959, 16'h0959, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 4, 16'h1000, 16'h1000, 16'h0960, 1, 0, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 1, 16'h5959, 1, 16'h5959, 16'h5959, 16'h5959, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 4, 16'h0000, 16'h0000, 16'h5960, 1, 0, 1, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h5960, 1, 0, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 1, 1, 16'h0002, 1, 16'h0002, 16'h0002, 16'h0002, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 1, 0, 16'h0000, 4, 16'h0001, 16'h0001, 16'h0001, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 1, 0, 16'h0000, 4, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1});
    v.push_back('{0, 0, 0, 1, 0, 16'h0000, 8, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 1, 16'h0013, 1, 16'h0013, 16'h0013, 16'h0013, 1, 0, 0, 0});
    v.push_back('{0, 0, 1, 0, 0, 16'h0000, 1, 16'h0013, 16'h0013, 16'h0013, 1, 1, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 11, 16'h0016, 16'h0013, 16'h0016, 1, 1, 0, 0});
    v.push_back('{0, 0, 1, 0, 0, 16'h0000, 1, 16'h0016, 16'h0016, 16'h0016, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 2, 16'h0016, 16'h0016, 16'h0016, 1, 0, 0, 0});
    v.push_back('{0, 0, 1, 0, 0, 16'h0000, 1, 16'h0017, 16'h0016, 16'h0017, 1, 1, 0, 0});
    v.push_back('{0, 0, 1, 0, 0, 16'h0000, 1, 16'h0017, 16'h0017, 16'h0017, 1, 0, 0, 0});
    v.push_back('{0, 0, 1, 0, 0, 16'h0000, 1, 16'h0017, 16'h0017, 16'h0017, 1, 1, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 3, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 0, 16'h0000, 1, 16'h0001, 16'h0001, 16'h0001, 1, 0, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 1, 16'h7A00, 1, 16'h5900, 16'h5900, 16'h7900, 0, 0, 0, 0});
    v.push_back('{1, 0, 0, 0, 0, 16'h0000, 1, 16'h5900, 16'h5900, 16'h7900, 1, 0, 0, 0});
    v.push_back('{0, 0, 0, 0, 1, 16'h0100, 1, 16'h5900, 16'h5900, 16'h7900, 1, 0, 0, 0});
    foreach (v[k]) begin
      {ss, cl, lp, dr, ld, lv} = {v[k].ss, v[k].cl, v[k].lp, v[k].dr, v[k].ld, v[k].lv};
      step(1);
      {ss, cl, lp, ld} = '0;
      step(v[k].n - 1);
      check($sformatf("v%0d count", k), count_a, v[k].ec);
      check($sformatf("v%0d disp", k), disp_a, v[k].ed);
      check($sformatf("v%0d count_b", k), count_b, v[k].eb);
      check($sformatf("v%0d running", k), 16'(run_a), 16'(v[k].er));
      check($sformatf("v%0d lap_active", k), 16'(lapa_a), 16'(v[k].ea));
      check($sformatf("v%0d wrap", k), 16'(wrap_a), 16'(v[k].ew));
      check($sformatf("v%0d done", k), 16'(done_a), 16'(v[k].eo));
    end
    // Mid-run reset with a lap freeze held, then restart timing from a cleared prescaler
    lp = 1;
    step(1);
    lp = 0;
    rst = 1;
    step(1);
    rst = 0;
    check("midrst count", count_a, 16'h0);
    check("midrst running", 16'(run_a), 16'h0);
    check("midrst lap_active", 16'(lapa_a), 16'h0);
    check("midrst disp", disp_a, 16'h0);
    check("midrst count_b", count_b, 16'h0);
    ss = 1;
    step(1);
    ss = 0;
    step(3);
    check("restart pre-tick", count_a, 16'h0);
    step(1);
    check("restart tick", count_a, 16'h0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
